uart_packet_deframer: RTL

//  Converts the raw byte stream from the UART receiver into the framed packet

---
 rtl/uart_packet_deframer_if.sv | 26 ++
 rtl/uart_packet_deframer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uart_packet_deframer_if.sv
// Byte-in / packet-out bundle between the UART receiver and the deframer.
// The slave modport is the deframer's view; master drives the receive side.
interface uart_packet_deframer_if;
    logic [7:0] ipRxData;
    logic       ipRxValid;
    logic [7:0] opData;
    logic       opValid;
    logic       opSoP;
    logic       opEoP;
    logic [7:0] opDestination;
    logic [7:0] opSource;
    logic [7:0] opLength;
    logic [7:0] opTimeoutCount;

    modport slave (
        input  ipRxData, ipRxValid,
        output opData, opValid, opSoP, opEoP,
        output opDestination, opSource, opLength, opTimeoutCount
    );

    modport master (
        output ipRxData, ipRxValid,
        input  opData, opValid, opSoP, opEoP,
        input  opDestination, opSource, opLength, opTimeoutCount
    );
endinterface

// File: rtl/uart_packet_deframer.sv
// Hunts for the sync byte, captures dest/src/len header, forwards payload
// with SoP/EoP markers; aborts and counts packets stalled between bytes.
module uart_packet_deframer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    uart_packet_deframer_if.slave bus
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, DEST, SRC, LEN, DATA
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    dst_sh_q, dst_sh_d;
    logic [7:0]    src_sh_q, src_sh_d;
    logic [7:0]    len_sh_q, len_sh_d;
    logic [7:0]    rem_q, rem_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic [7:0]    dst_q, dst_d;
    logic [7:0]    src_q, src_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    tcnt_q, tcnt_d;

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            state_q  <= IDLE;
            dst_sh_q <= '0;
            src_sh_q <= '0;
            len_sh_q <= '0;
            rem_q    <= '0;
            tmo_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            dst_q    <= '0;
            src_q    <= '0;
            len_q    <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            dst_sh_q <= dst_sh_d;
            src_sh_q <= src_sh_d;
            len_sh_q <= len_sh_d;
            rem_q    <= rem_d;
            tmo_q    <= tmo_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            len_q    <= len_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dst_sh_d = dst_sh_q;
        src_sh_d = src_sh_q;
        len_sh_d = len_sh_q;
        rem_d    = rem_q;
        tmo_d    = tmo_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        dst_d    = dst_q;
        src_d    = src_q;
        len_d    = len_q;
        tcnt_d   = tcnt_q;

        // A byte always beats a timeout landing on the same cycle
        if (bus.ipRxValid) begin
            tmo_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (bus.ipRxData == SYNC_BYTE) begin
                        state_d = DEST;
                    end
                end
                DEST: begin
                    dst_sh_d = bus.ipRxData;
                    state_d  = SRC;
                end
                SRC: begin
                    src_sh_d = bus.ipRxData;
                    state_d  = LEN;
                end
                LEN: begin
                    len_sh_d = bus.ipRxData;
                    rem_d    = bus.ipRxData;
                    state_d  = (bus.ipRxData == 8'd0) ? IDLE : DATA;
                end
                DATA: begin
                    data_d  = bus.ipRxData;
                    valid_d = 1'b1;
                    rem_d   = rem_q - 8'd1;
                    // Header fields only become visible with the first byte
                    if (rem_q == len_sh_q) begin
                        sop_d = 1'b1;
                        dst_d = dst_sh_q;
                        src_d = src_sh_q;
                        len_d = len_sh_q;
                    end
                    if (rem_q == 8'd1) begin
                        eop_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d   = '0;
            state_d = IDLE;
            if (tcnt_q != 8'hFF) begin
                tcnt_d = tcnt_q + 8'd1;
            end
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    assign bus.opData         = data_q;
    assign bus.opValid        = valid_q;
    assign bus.opSoP          = sop_q;
    assign bus.opEoP          = eop_q;
    assign bus.opDestination  = dst_q;
    assign bus.opSource       = src_q;
    assign bus.opLength       = len_q;
    assign bus.opTimeoutCount = tcnt_q;
endmodule
